// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and geometry for the data memory and its arbiter
package dmem_pkg;
  localparam int AW = 15;
  localparam int DW = 48;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin sequencer in front of the data memory
module dmem_arbiter #(
  parameter int AW = dmem_pkg::AW,
  parameter int DW = dmem_pkg::DW,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_a_req,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic          o_a_ack,
  output logic [DW-1:0] o_a_rdata,
  input  logic          i_b_req,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic          o_b_ack,
  output logic [DW-1:0] o_b_rdata,
  output logic          o_err,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_done
);
  import dmem_pkg::*;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t        state;
  port_t         grant, last_grant;
  logic          we;
  logic [7:0]    wd;
  logic          pick_b, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // B wins when it is alone or when A was served last
  assign pick_b    = i_b_req && (!i_a_req || last_grant == PORT_A);
  assign sel_we    = pick_b ? i_b_we : i_a_we;
  assign sel_addr  = pick_b ? i_b_addr : i_a_addr;
  assign sel_wdata = pick_b ? i_b_wdata : i_a_wdata;

  // Sequencer: strobes and acks default low so every pulse lasts one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= PORT_A;
      last_grant  <= PORT_B;
      we          <= 1'b0;
      wd          <= '0;
      o_a_ack     <= 1'b0;
      o_b_ack     <= 1'b0;
      o_err       <= 1'b0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_a_rdata   <= '0;
      o_b_rdata   <= '0;
    end else begin
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_a_ack     <= 1'b0;
      o_b_ack     <= 1'b0;
      o_err       <= 1'b0;
      case (state)
        IDLE: if (i_a_req || i_b_req) begin
          grant       <= pick_b ? PORT_B : PORT_A;
          we          <= sel_we;
          o_mem_addr  <= sel_addr;
          o_mem_wdata <= sel_wdata;
          o_mem_read  <= !sel_we;
          o_mem_write <= sel_we;
          state       <= ISSUE;
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: if (i_mem_done || wd == WD_LAST) begin
          if (i_mem_done && !we && grant == PORT_A) o_a_rdata <= i_mem_rdata;
          if (i_mem_done && !we && grant == PORT_B) o_b_rdata <= i_mem_rdata;
          o_a_ack <= grant == PORT_A;
          o_b_ack <= grant == PORT_B;
          o_err   <= !i_mem_done;
          state   <= ACK;
        end else wd <= wd + 8'd1;
        default: begin
          last_grant <= grant;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors plus randomized scoreboard for dmem_arbiter
module tb_dmem_arbiter;
  localparam int AW = 15;
  localparam int DW = 48;
  localparam int TO = 15;

  logic          clk = 1'b0, reset = 1'b0;
  logic          i_a_req = 1'b0, i_a_we = 1'b0, i_b_req = 1'b0, i_b_we = 1'b0;
  logic [AW-1:0] i_a_addr = '0, i_b_addr = '0;
  logic [DW-1:0] i_a_wdata = '0, i_b_wdata = '0;
  logic          o_a_ack, o_b_ack, o_err, o_mem_read, o_mem_write;
  logic [DW-1:0] o_a_rdata, o_b_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          i_mem_done = 1'b0;

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_a_req(i_a_req), .i_a_we(i_a_we), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata),
    .o_a_ack(o_a_ack), .o_a_rdata(o_a_rdata),
    .i_b_req(i_b_req), .i_b_we(i_b_we), .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata),
    .o_b_ack(o_b_ack), .o_b_rdata(o_b_rdata),
    .o_err(o_err), .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_done(i_mem_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: done one cycle after a strobe, address 0 always reads zero
  logic [DW-1:0] mem [int];
  bit            suppress = 0, pend = 0;
  logic [DW-1:0] pend_d = '0;

  function automatic logic [DW-1:0] mrd(input int a);
    return (a == 0 || !mem.exists(a)) ? '0 : mem[a];
  endfunction

  initial forever begin
    step();
    i_mem_done  = pend;
    i_mem_rdata = pend ? pend_d : {16'($urandom), $urandom};
    pend        = (o_mem_read || o_mem_write) && !suppress;
    pend_d      = o_mem_read ? mrd(int'(o_mem_addr)) : '0;
    if (o_mem_write) mem[int'(o_mem_addr)] = o_mem_wdata;
  end

  task automatic set_req(input bit p, input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin
      i_b_req = r; i_b_we = w; i_b_addr = a; i_b_wdata = d;
    end else begin
      i_a_req = r; i_a_we = w; i_a_addr = a; i_a_wdata = d;
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_ctl"}, {43'd0, o_a_ack, o_b_ack, o_err, o_mem_read, o_mem_write}, '0);
    chk({n, "_addr"}, DW'(o_mem_addr), '0);
    chk({n, "_wdata"}, o_mem_wdata, '0);
    chk({n, "_a_rdata"}, o_a_rdata, '0);
    chk({n, "_b_rdata"}, o_b_rdata, '0);
  endtask

  // One transaction on port p issued in an IDLE cycle; ack cycle counted from that cycle
  task automatic txn(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input int exp_ack, input bit exp_err);
    int sc, ac;
    bit wrong;
    sc = -1; ac = -1; wrong = 0;
    set_req(p, 1'b1, w, a, d);
    for (int i = 1; i <= 40 && ac < 0; i++) begin
      step();
      if ((o_mem_read || o_mem_write) && sc < 0) begin
        sc = i;
        chk("strobe_write", DW'(o_mem_write), DW'(w));
        chk("strobe_addr", DW'(o_mem_addr), DW'(a));
        if (w) chk("strobe_wdata", o_mem_wdata, d);
      end
      if (p ? o_a_ack : o_b_ack) wrong = 1;
      if (p ? o_b_ack : o_a_ack) begin
        ac = i;
        chk("ack_err", DW'(o_err), DW'(exp_err));
      end
    end
    step();
    set_req(p, 1'b0, 1'b0, '0, '0);
    chk("strobe_cycle", DW'(sc), DW'(1));
    chk("ack_cycle", DW'(ac), DW'(exp_ack));
    chk("other_ack", DW'(wrong), '0);
  endtask

  typedef struct {
    bit            p;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vt[8];
  int   ack_c[$];
  bit   ack_p[$];

  initial begin
    bit            rq[2], rw[2], ackp[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rd[2], rdexp[2], exp_val;
    logic [DW-1:0] ref_mem [int];
    logic [1:0]    ea;
    int            infl, due, last, g, acked;
    bit            bad;

    mem[5] = 48'h1234_5678_9ABC;
    mem[9] = 48'hDEAD_BEEF_0001;
    vt[0] = '{0, 0, 15'd5, 48'h0, 48'h1234_5678_9ABC};
    vt[1] = '{1, 1, 15'd7, 48'hFFFF_0000_FFFF, 48'h0};
    vt[2] = '{1, 0, 15'd7, 48'h0, 48'hFFFF_0000_FFFF};
    vt[3] = '{0, 1, 15'd0, 48'h1, 48'h1234_5678_9ABC};
    vt[4] = '{0, 0, 15'd0, 48'h0, 48'h0};
    vt[5] = '{1, 1, 15'd7, 48'h0000_1111_2222, 48'hFFFF_0000_FFFF};
    vt[6] = '{0, 0, 15'd5, 48'h0, 48'h1234_5678_9ABC};
    vt[7] = '{1, 0, 15'd7, 48'h0, 48'h0000_1111_2222};

    #2 reset = 1'b1;
    #1 chk_zero("reset");
    step(); step();
    reset = 1'b0;

    foreach (vt[i]) begin
      txn(vt[i].p, vt[i].w, vt[i].a, vt[i].d, 3, 1'b0);
      chk($sformatf("vec%0d_rdata", i), vt[i].p ? o_b_rdata : o_a_rdata, vt[i].exp_rd);
    end

    suppress = 1;
    txn(0, 0, 15'd9, '0, 2 + TO, 1'b1);
    chk("timeout_rdata_kept", o_a_rdata, 48'h1234_5678_9ABC);
    suppress = 0;
    txn(0, 0, 15'd9, '0, 3, 1'b0);
    chk("after_timeout_rdata", o_a_rdata, 48'hDEAD_BEEF_0001);

    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 15'd5, '0);
    set_req(1, 1'b1, 1'b0, 15'd7, '0);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (o_a_ack) begin ack_c.push_back(i); ack_p.push_back(0); end
      if (o_b_ack) begin ack_c.push_back(i); ack_p.push_back(1); end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    chk("alt_count", DW'(ack_c.size()), DW'(4));
    for (int i = 0; i < 4 && i < ack_c.size(); i++) begin
      chk($sformatf("alt%0d_cycle", i), DW'(ack_c[i]), DW'(3 + 4 * i));
      chk($sformatf("alt%0d_port", i), DW'(ack_p[i]), DW'(i % 2));
    end
    repeat (6) step();

    set_req(0, 1'b1, 1'b0, 15'd5, '0);
    step(); step();
    reset = 1'b1;
    #1 chk_zero("rst_wait");
    set_req(0, 1'b0, 1'b0, '0, '0);
    step();
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      step();
      bad |= o_a_ack | o_b_ack | o_err | o_mem_read | o_mem_write;
    end
    chk("no_ack_after_reset", DW'(bad), '0);
    set_req(0, 1'b1, 1'b0, 15'd5, '0);
    set_req(1, 1'b1, 1'b0, 15'd7, '0);
    step();
    chk("afirst_addr", DW'(o_mem_addr), DW'(5));
    step(); step();
    chk("afirst_ack", {46'd0, o_b_ack, o_a_ack}, DW'(2'b01));
    chk("afirst_rdata", o_a_rdata, 48'h1234_5678_9ABC);
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (4) step();

    ref_mem = mem;
    rdexp[0] = 48'h1234_5678_9ABC;
    rdexp[1] = '0;
    rq = '{0, 0}; rw = '{0, 0}; ackp = '{0, 0};
    ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0;
    infl = -1; due = 0; last = 0; exp_val = '0;
    for (int c = 0; c < 800; c++) begin
      step();
      acked = -1;
      if (o_mem_read || o_mem_write) begin
        g = (rq[0] && rq[1]) ? (last == 0 ? 1 : 0) : (rq[1] ? 1 : 0);
        chk("rnd_strobe_legal", DW'(infl >= 0 || !(rq[0] || rq[1])), '0);
        chk("rnd_kind", DW'(o_mem_write), DW'(rw[g]));
        chk("rnd_addr", DW'(o_mem_addr), DW'(ra[g]));
        if (rw[g]) begin
          chk("rnd_wdata", o_mem_wdata, rd[g]);
          ref_mem[int'(ra[g])] = rd[g];
        end
        exp_val = rw[g] ? rdexp[g] :
                  (ra[g] == '0 || !ref_mem.exists(int'(ra[g]))) ? '0 : ref_mem[int'(ra[g])];
        infl = g;
        due  = c + 2;
      end
      if (o_a_ack || o_b_ack || (infl >= 0 && c == due)) begin
        ea = (infl >= 0 && c == due) ? (infl == 1 ? 2'b10 : 2'b01) : 2'b00;
        chk("rnd_ack", {46'd0, o_b_ack, o_a_ack}, DW'(ea));
        if (ea != 2'b00) begin
          rdexp[infl] = exp_val;
          chk("rnd_err", DW'(o_err), '0);
          chk("rnd_a_rdata", o_a_rdata, rdexp[0]);
          chk("rnd_b_rdata", o_b_rdata, rdexp[1]);
          last  = infl;
          acked = infl;
          infl  = -1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (ackp[p]) begin
          rq[p]   = 0;
          ackp[p] = 0;
        end
        if (!rq[p] && $urandom_range(0, 2) == 0) begin
          rq[p] = 1;
          rw[p] = 1'($urandom);
          ra[p] = AW'($urandom_range(0, 7));
          rd[p] = {16'($urandom), $urandom};
        end
        if (acked == p) ackp[p] = 1;
        set_req(p[0], rq[p], rw[p], ra[p], rd[p]);
      end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
